// File: rtl/alu_pkg.sv
// ============================================================================
// Package : alu_pkg
// Shared opcode constants, writeback class encoding and writeback FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Opcodes shared with the ALU.
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;

    // Destination class of a buffered result.
    typedef enum logic [1:0] {
        CL_RF   = 2'd0,
        CL_MAR  = 2'd1,
        CL_PAIR = 2'd2,
        CL_DROP = 2'd3
    } wb_class_e;

    // Writeback sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_RF  = 3'd1,
        ST_WR_MAR = 3'd2,
        ST_WR_LO  = 3'd3,
        ST_WR_HI  = 3'd4
    } wb_state_e;

    // Map an opcode to the sink that receives its result.
    function automatic wb_class_e wb_classify(input logic [4:0] op);
        wb_class_e cls;
        cls = CL_DROP;
        if (op == OP_MUL || op == OP_DIV) begin
            cls = CL_PAIR;
        end else if (op == OP_LOAD || op == OP_STORE) begin
            cls = CL_MAR;
        end else if (op == 5'b00001 || (op >= 5'b00011 && op <= 5'b01110) ||
                     op == 5'b10001 || op == 5'b10010) begin
            cls = CL_RF;
        end
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module  : wb_fifo
// Small synchronous FIFO with registered full/empty status and async clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_writeback.sv
// ============================================================================
// Module  : alu_writeback
// Buffers ALU results and steers them to RF, HI/LO or MAR over a granted bus.
// Optional: define ALU_WB_FWD_EN to add the fwd_* operand-forwarding outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_z,
    input  logic [4:0]          in_opcode,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic                bus_grant,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic                lo_we,
    output logic                hi_we,
    output logic                mar_we,
    output logic [DATA_W-1:0]   wdata,
    output logic                busy
`ifdef ALU_WB_FWD_EN
    ,
    output logic                fwd_valid,
    output logic [REG_AW-1:0]   fwd_addr,
    output logic [DATA_W-1:0]   fwd_data
`endif
);

    localparam int ENTRY_W = 2*DATA_W + 5 + REG_AW;

    logic [ENTRY_W-1:0]  head;
    logic                full, empty, push, pop;
    logic [2*DATA_W-1:0] head_z;
    logic [4:0]          head_op;
    logic [REG_AW-1:0]   head_rd;
    wb_class_e           head_cls;
    wb_state_e           state_q, state_d;

    // Ready depends only on registered FIFO state, forced low during reset.
    assign in_ready = !full && clr;
    assign push     = in_valid && in_ready;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata ({in_z, in_opcode, in_rd}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_z   = head[ENTRY_W-1 -: 2*DATA_W];
    assign head_op  = head[REG_AW +: 5];
    assign head_rd  = head[REG_AW-1:0];
    assign head_cls = wb_classify(head_op);
    assign busy     = !empty || (state_q != ST_IDLE);

    // Sequencer state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state, pop and Moore strobes; the head is popped on its final beat.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        rf_we    = 1'b0;
        lo_we    = 1'b0;
        hi_we    = 1'b0;
        mar_we   = 1'b0;
        rf_waddr = '0;
        wdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    case (head_cls)
                        CL_RF:   state_d = ST_WR_RF;
                        CL_MAR:  state_d = ST_WR_MAR;
                        CL_PAIR: state_d = ST_WR_LO;
                        default: pop     = 1'b1;
                    endcase
                end
            end
            ST_WR_RF: begin
                rf_we    = 1'b1;
                rf_waddr = head_rd;
                wdata    = head_z[DATA_W-1:0];
                if (bus_grant) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_MAR: begin
                mar_we = 1'b1;
                wdata  = head_z[DATA_W-1:0];
                if (bus_grant) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_LO: begin
                lo_we = 1'b1;
                wdata = head_z[DATA_W-1:0];
                if (bus_grant) state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                hi_we = 1'b1;
                wdata = head_z[2*DATA_W-1:DATA_W];
                if (bus_grant) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ALU_WB_FWD_EN
    logic              fwd_valid_q;
    logic [REG_AW-1:0] fwd_addr_q;
    logic [DATA_W-1:0] fwd_data_q;

    // Capture each committed RF write for exactly one cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else if (rf_we && bus_grant) begin
            fwd_valid_q <= 1'b1;
            fwd_addr_q  <= rf_waddr;
            fwd_data_q  <= wdata;
        end else begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_addr  = fwd_addr_q;
    assign fwd_data  = fwd_data_q;
`endif

endmodule

`default_nettype wire
